// File: rtl/iter_multiply.sv
// iter_multiply: iterative shift-and-add signed/unsigned multiplier, RADIX_BITS multiplier bits per cycle.
// Optional MULT_EARLY_TERM_EN: leave CALC as soon as the remaining multiplier bits are all zero.
module iter_multiply #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mult_begin,
  input  logic               mult_signed,
  input  logic [WIDTH-1:0]   mult_op1,
  input  logic [WIDTH-1:0]   mult_op2,
  output logic [2*WIDTH-1:0] product,
  output logic               mult_end,
  output logic               busy
);
  localparam int N  = WIDTH / RADIX_BITS;
  localparam int CW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t               state_q;
  logic [2*WIDTH-1:0]   acc_q, mcand_q, product_q, psum, acc_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d, op1_mag, op2_mag;
  logic [CW-1:0]        cnt_q;
  logic                 sign_q, mult_end_q, busy_q, last;
  // Operate on magnitudes so the most negative value becomes 2^(WIDTH-1).
  always_comb begin
    op1_mag  = (mult_signed & mult_op1[WIDTH-1]) ? -mult_op1 : mult_op1;
    op2_mag  = (mult_signed & mult_op2[WIDTH-1]) ? -mult_op2 : mult_op2;
    psum     = '0;
    for (int i = 0; i < RADIX_BITS; i++)
      psum = psum + (mplier_q[i] ? (mcand_q << i) : '0);
    acc_d    = acc_q + psum;
    mplier_d = mplier_q >> RADIX_BITS;
`ifdef MULT_EARLY_TERM_EN
    last     = (cnt_q == CW'(N - 1)) || (mplier_d == '0);
`else
    last     = cnt_q == CW'(N - 1);
`endif
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      cnt_q      <= '0;
      sign_q     <= 1'b0;
      product_q  <= '0;
      mult_end_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mult_end_q <= 1'b0;
      case (state_q)
        IDLE: if (mult_begin) begin
          mcand_q  <= {{WIDTH{1'b0}}, op1_mag};
          mplier_q <= op2_mag;
          sign_q   <= mult_signed & (mult_op1[WIDTH-1] ^ mult_op2[WIDTH-1]);
          acc_q    <= '0;
          cnt_q    <= '0;
          busy_q   <= 1'b1;
          state_q  <= CALC;
        end
        CALC: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << RADIX_BITS;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CW'(1);
          if (last) begin
            product_q  <= sign_q ? -acc_d : acc_d;
            mult_end_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign product  = product_q;
  assign mult_end = mult_end_q;
  assign busy     = busy_q;
endmodule

// File: tb/tb_iter_multiply.sv
// tb_iter_multiply: directed and random checks of iter_multiply against a sign-extend-and-multiply model.
module tb_iter_multiply;
  localparam int W = 32, R = 2, N = W / R;
  logic             clk = 1'b0, rst = 1'b0, mult_begin = 1'b0, mult_signed = 1'b0;
  logic [W-1:0]     mult_op1 = '0, mult_op2 = '0;
  logic [2*W-1:0]   product;
  logic             mult_end, busy;
  int               checks = 0, errors = 0;
  iter_multiply #(.WIDTH(W), .RADIX_BITS(R)) dut (
    .clk(clk), .rst(rst), .mult_begin(mult_begin), .mult_signed(mult_signed),
    .mult_op1(mult_op1), .mult_op2(mult_op2), .product(product),
    .mult_end(mult_end), .busy(busy)
  );
  always #5 clk = ~clk;
  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction
  // Cycles from acceptance to the mult_end cycle, counting the cycle after acceptance as 1.
  function automatic int lat(input logic s, input logic [W-1:0] b);
    logic [W-1:0] m;
    int nb;
    m  = (s && b[W-1]) ? -b : b;
    nb = 0;
    for (int i = 0; i < W; i++) if (m[i]) nb = i + 1;
`ifdef MULT_EARLY_TERM_EN
    return 1 + ((nb == 0) ? 1 : (nb + R - 1) / R);
`else
    return (nb >= 0) ? N + 1 : 0;
`endif
  endfunction
  task automatic chk(input string tag, input logic [2*W-1:0] obs, input logic [2*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic run(input string tag, input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    int cyc;
    mult_signed = s; mult_op1 = a; mult_op2 = b; mult_begin = 1'b1;
    @(posedge clk); #1;
    mult_begin = 1'b0;
    chk({tag, " busy"}, 64'(busy), 64'd1);
    cyc = 1;
    while (mult_end !== 1'b1 && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, " end"}, 64'(mult_end), 64'd1);
    chk({tag, " lat"}, 64'(cyc), 64'(lat(s, b)));
    chk({tag, " prod"}, product, model(s, a, b));
    @(posedge clk); #1;
    chk({tag, " pulse"}, 64'({mult_end, busy}), 64'd0);
  endtask
  initial begin
    int cyc, pulses;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst", 64'({mult_end, busy}), 64'd0);
    chk("rst prod", product, 64'd0);
    rst = 1'b0;
    run("uu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("uu_max const", product, 64'hFFFF_FFFE_0000_0001);
    run("s_neg3x5", 1'b1, 32'hFFFF_FFFD, 32'd5);
    chk("s_neg3x5 const", product, 64'hFFFF_FFFF_FFFF_FFF1);
    run("u_3x5", 1'b0, 32'hFFFF_FFFD, 32'd5);
    chk("u_3x5 const", product, 64'h4_FFFF_FFF1);
    run("s_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000);
    chk("s_minmin const", product, 64'h4000_0000_0000_0000);
    run("s_minx1", 1'b1, 32'h8000_0000, 32'd1);
    chk("s_minx1 const", product, 64'hFFFF_FFFF_8000_0000);
    run("zero", 1'b0, 32'h1234_5678, 32'd0);
    run("op2_3", 1'b0, 32'hDEAD_BEEF, 32'd3);
    run("s_op2_min", 1'b1, 32'h0000_0007, 32'h8000_0000);
    // Held begin: requests during CALC/DONE must be dropped, not queued.
    mult_signed = 1'b0; mult_op1 = 32'd7; mult_op2 = 32'd6; mult_begin = 1'b1;
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (mult_end !== 1'b1 && cyc < 60);
      chk("held end", 64'(mult_end), 64'd1);
      chk("held prod", product, 64'd42);
      chk("held gap", 64'(cyc), 64'((p == 0) ? lat(1'b0, 32'd6) : lat(1'b0, 32'd6) + 1));
    end
    mult_begin = 1'b0;
    pulses = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (mult_end === 1'b1) pulses++;
    end
    chk("idle pulses", 64'(pulses), 64'd0);
    chk("idle busy", 64'(busy), 64'd0);
    chk("idle hold", product, 64'd42);
    // Reset during the fifth CALC cycle discards the operation.
    mult_signed = 1'b0; mult_op1 = 32'hFFFF_FFFF; mult_op2 = 32'hFFFF_FFFF; mult_begin = 1'b1;
    @(posedge clk); #1;
    mult_begin = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst prod", product, 64'd0);
    chk("midrst outs", 64'({mult_end, busy}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (mult_end === 1'b1 || busy === 1'b1) pulses++;
    end
    chk("midrst quiet", 64'(pulses), 64'd0);
    run("post_rst", 1'b0, 32'd2, 32'd3);
    chk("post_rst const", product, 64'd6);
    repeat (15) run("rnd", 1'($urandom_range(0, 1)), $urandom, $urandom);
    repeat (10) run("rnd_small", 1'($urandom_range(0, 1)), $urandom, $urandom >> $urandom_range(0, 31));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end
endmodule
